// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// The response struct is sized by IMEM_BUS_WIDTH; the top-level BUS_WIDTH must match it.
package imem_pkg;

    localparam int unsigned IMEM_BUS_WIDTH = 32;

    // Bubble returned in place of an instruction for out-of-range fetches.
    localparam logic [IMEM_BUS_WIDTH-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [IMEM_BUS_WIDTH-1:0] addr;
        logic [IMEM_BUS_WIDTH-1:0] instr;
        logic                      err;
    } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO of imem_rsp_t entries; DEPTH must be a power of two.
// Push while full is accepted only when a pop happens in the same cycle.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  imem_rsp_t push_data_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output imem_rsp_t head_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    imem_rsp_t       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: array, fixed-latency read pipeline and credit-limited response FIFO.
// Define IMEM_STATS_EN to add the stat_req_cnt / stat_stall_cnt counters.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = IMEM_BUS_WIDTH,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BUS_WIDTH-1:0]  req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BUS_WIDTH-1:0]  rsp_instr,
    output logic [BUS_WIDTH-1:0]  rsp_addr,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [BUS_WIDTH-1:0]  ld_data,
    output logic                  busy
`ifdef IMEM_STATS_EN
    ,
    output logic [BUS_WIDTH-1:0]  stat_req_cnt,
    output logic [BUS_WIDTH-1:0]  stat_stall_cnt
`endif
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] MaxOutstanding = CntW'(FIFO_DEPTH);

    logic [BUS_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    imem_rsp_t            stage0_d;
    imem_rsp_t            pipe_q [LATENCY];
    logic [LATENCY-1:0]   pipe_vld_q;

    logic [CntW-1:0]      outstanding_q, outstanding_d;
    logic                 accept, rsp_hs, addr_oob;

    logic                 fifo_full, fifo_empty;
    imem_rsp_t            fifo_head;
    logic                 unused_fifo_full;

    assign unused_fifo_full = fifo_full;

    assign req_ready = !RST && !ld_en && (outstanding_q < MaxOutstanding);
    assign accept    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign busy      = (outstanding_q != '0);

    // Upper address bits only decide the error flag; the low bits index the array.
    assign addr_oob = |(req_addr >> DEPTH_LOG2);

    always_comb begin
        stage0_d.addr  = req_addr;
        stage0_d.err   = addr_oob;
        stage0_d.instr = addr_oob ? NOP_INSTR : mem_q[req_addr[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge CLK) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        pipe_q[0] <= stage0_d;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !rsp_hs) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!accept && rsp_hs) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // Credits bound the pipeline plus FIFO occupancy, so the push never meets a full FIFO.
    imem_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (pipe_vld_q[LATENCY-1]),
        .push_data_i (pipe_q[LATENCY-1]),
        .pop_i       (rsp_hs),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_instr = fifo_empty ? '0 : fifo_head.instr;
    assign rsp_addr  = fifo_empty ? '0 : fifo_head.addr;
    assign rsp_err   = fifo_empty ? 1'b0 : fifo_head.err;

`ifdef IMEM_STATS_EN
    logic [BUS_WIDTH-1:0] stat_req_q, stat_stall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_req_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (accept) begin
                stat_req_q <= stat_req_q + 1'b1;
            end
            if (req_valid && !req_ready) begin
                stat_stall_q <= stat_stall_q + 1'b1;
            end
        end
    end

    assign stat_req_cnt   = stat_req_q;
    assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a reference model predicts handshakes and response contents.
// Define IMEM_STATS_EN to also check the statistics counters.
module tb_imem_responder;

    localparam int unsigned BW  = 32;
    localparam int unsigned DL  = 8;
    localparam int unsigned LAT = 2;
    localparam int unsigned FD  = 4;
    localparam int unsigned NW  = 1 << DL;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [BW-1:0] req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [BW-1:0] rsp_instr;
    logic [BW-1:0] rsp_addr;
    logic          rsp_err;
    logic          ld_en = 1'b0;
    logic [DL-1:0] ld_addr = '0;
    logic [BW-1:0] ld_data = '0;
    logic          busy;
`ifdef IMEM_STATS_EN
    logic [BW-1:0] stat_req_cnt;
    logic [BW-1:0] stat_stall_cnt;
    logic [BW-1:0] m_req_cnt = '0;
    logic [BW-1:0] m_stall_cnt = '0;
`endif

    imem_responder #(
        .BUS_WIDTH  (BW),
        .DEPTH_LOG2 (DL),
        .LATENCY    (LAT),
        .FIFO_DEPTH (FD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .busy      (busy)
`ifdef IMEM_STATS_EN
        ,
        .stat_req_cnt   (stat_req_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [BW-1:0] addr;
        logic [BW-1:0] instr;
        logic          err;
        int            rdy;
    } exp_t;

    exp_t          exp_q[$];
    logic [BW-1:0] ref_mem [NW];
    int            out_m = 0;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] want);
        n_chk++;
        if (act !== want) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Model: a request accepted during cycle c is visible from cycle c+1+LAT, in order.
    always @(negedge CLK) begin
        exp_t f;
        exp_t n;
        logic exp_ready;
        logic exp_valid;
        if (mon_en) begin
            exp_ready = !RST && !ld_en && (out_m < FD);
            exp_valid = (exp_q.size() != 0) && (exp_q[0].rdy <= cyc);
            check("req_ready", req_ready, exp_ready);
            check("busy", busy, out_m != 0);
            check("rsp_valid", rsp_valid, exp_valid);
            if (exp_valid) begin
                f = exp_q[0];
                check("rsp_addr", rsp_addr, f.addr);
                check("rsp_instr", rsp_instr, f.instr);
                check("rsp_err", rsp_err, f.err);
            end
`ifdef IMEM_STATS_EN
            check("stat_req_cnt", stat_req_cnt, m_req_cnt);
            check("stat_stall_cnt", stat_stall_cnt, m_stall_cnt);
`endif
            if (RST) begin
                exp_q.delete();
                out_m = 0;
`ifdef IMEM_STATS_EN
                m_req_cnt   = '0;
                m_stall_cnt = '0;
`endif
            end else begin
                if (exp_valid && rsp_ready) begin
                    void'(exp_q.pop_front());
                    out_m--;
                end
                if (req_valid && exp_ready) begin
                    n.addr  = req_addr;
                    n.err   = (req_addr >= NW);
                    n.instr = n.err ? '0 : ref_mem[req_addr % NW];
                    n.rdy   = cyc + 1 + LAT;
                    exp_q.push_back(n);
                    out_m++;
                end
`ifdef IMEM_STATS_EN
                if (req_valid && exp_ready) m_req_cnt = m_req_cnt + 1;
                if (req_valid && !exp_ready) m_stall_cnt = m_stall_cnt + 1;
`endif
            end
        end
        if (ld_en) ref_mem[ld_addr] = ld_data;
    end

    initial begin
        // Preload while held in reset, then hold reset two more cycles.
        tick();
        mon_en = 1'b1;
        for (int i = 0; i < NW; i++) begin
            ld_en   = 1'b1;
            ld_addr = DL'(i);
            ld_data = (i < 4) ? BW'((i + 1) * 'h11) : $urandom;
            tick();
        end
        ld_en = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_instr", rsp_instr, 0);
        check("reset_rsp_addr", rsp_addr, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_busy", busy, 0);
        tick();

        // Back-to-back fetch of words 0..3.
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = BW'(i);
            tick();
        end
        req_valid = 1'b0;
        repeat (6) tick();

        // Back-pressure: only FD accepts while the consumer stalls.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = BW'($urandom_range(0, NW - 1));
            tick();
        end
        @(negedge CLK);
        check("stall_req_ready", req_ready, 0);
        check("stall_busy", busy, 1);
        tick();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = BW'($urandom_range(0, NW - 1));
            tick();
        end
        req_valid = 1'b0;
        repeat (8) tick();

        // Out-of-range addresses.
        req_valid = 1'b1;
        req_addr  = BW'(NW);
        tick();
        req_addr = 32'hFFFF_FFFF;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();

        // Loader write blocks the same-cycle request; the next read sees new data.
        ld_en     = 1'b1;
        ld_addr   = 8'h10;
        ld_data   = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        tick();
        ld_en = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();

        // Reset with three requests outstanding.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = BW'($urandom_range(0, NW - 1));
            tick();
        end
        req_valid = 1'b0;
        RST       = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("post_reset_rsp_valid", rsp_valid, 0);
        check("post_reset_busy", busy, 0);
        tick();
        rsp_ready = 1'b1;
        repeat (6) tick();

        // Randomized traffic with occasional loads and resets.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_addr  = ($urandom_range(0, 9) == 0) ? BW'($urandom) : BW'($urandom_range(0, NW - 1));
            rsp_ready = ($urandom_range(0, 9) < 6);
            ld_en     = ($urandom_range(0, 19) == 0);
            ld_addr   = DL'($urandom);
            ld_data   = $urandom;
            RST       = ($urandom_range(0, 199) == 0);
            tick();
        end
        RST       = 1'b0;
        req_valid = 1'b0;
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) tick();
        @(negedge CLK);
        check("drained_queue", BW'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
